// File: rtl/mesh_sort_pkg.sv
// ============================================================================
// Module      : mesh_sort_pkg
// Description : Shared types and sizing helpers for the shearsort mesh.
//               - state_e    : sorter FSM states
//               - nr_f       : number of row phases      (clog2(ROWS)+1)
//               - nc_f       : number of column phases   (clog2(ROWS))
//               - n_steps_f  : total compare-exchange steps per sort
//               - p_idx_f    : flat key index of grid cell (r,c)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mesh_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int nr_f(input int rows);
    return $clog2(rows) + 1;
  endfunction

  function automatic int nc_f(input int rows);
    return $clog2(rows);
  endfunction

  function automatic int n_steps_f(input int rows, input int cols);
    return nr_f(rows) * cols + nc_f(rows) * rows;
  endfunction

  function automatic int p_idx_f(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mesh_cmp_swap.sv
// ============================================================================
// Module      : mesh_cmp_swap
// Description : Combinational compare-exchange for one adjacent key pair.
//               a_i sits at the lower-index position, b_i at the higher.
//               desc_i=0 orders the pair ascending, desc_i=1 descending.
//               lo_o is the key for the lower-index position, hi_o for the
//               higher one. Keys move only when strictly out of order, so
//               equal keys never swap.
// Ports       : a_i, b_i   in  KEY_W  pair inputs
//               desc_i     in  1      ordering direction
//               lo_o, hi_o out KEY_W  ordered pair
//               swapped_o  out 1      pair was exchanged
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_cmp_swap
  import mesh_sort_pkg::*;
#(
  parameter int KEY_W = 4
) (
  input  logic [KEY_W-1:0] a_i,
  input  logic [KEY_W-1:0] b_i,
  input  logic             desc_i,
  output logic [KEY_W-1:0] lo_o,
  output logic [KEY_W-1:0] hi_o,
  output logic             swapped_o
);

  logic w_out_of_order;

  assign w_out_of_order = desc_i ? (a_i < b_i) : (a_i > b_i);
  assign swapped_o      = w_out_of_order;
  assign lo_o           = w_out_of_order ? b_i : a_i;
  assign hi_o           = w_out_of_order ? a_i : b_i;

endmodule

`default_nettype wire

// File: rtl/mesh_shearsort.sv
// ============================================================================
// Module      : mesh_shearsort
// Description : ROWS x COLS mesh of KEY_W-bit key registers sorted into snake
//               order by shearsort. Row phases (odd-even transposition, even
//               rows ascending, odd rows descending) alternate with column
//               phases (ascending top to bottom), starting and ending on a
//               row phase. One transposition step per clock.
// Ports       : clk       in   1               rising-edge clock
//               rst       in   1               async reset, active-low
//               start     in   1               sort request (IDLE only)
//               data_in   in   ROWS*COLS*KEY_W key p=r*COLS+c at p*KEY_W
//               busy      out  1               sort in progress
//               done      out  1               one-cycle result-valid pulse
//               data_out  out  ROWS*COLS*KEY_W grid contents, same packing
// Config      : MESH_SORT_EARLY_EXIT_EN - when defined, a row phase followed
//               by a column phase that both made no swap ends the sort early.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_shearsort
  import mesh_sort_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int KEY_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROWS*COLS*KEY_W-1:0]  data_in,
  output logic                        busy,
  output logic                        done,
  output logic [ROWS*COLS*KEY_W-1:0]  data_out
);

  localparam int NR      = nr_f(ROWS);
  localparam int NC      = nc_f(ROWS);
  localparam int NPH     = NR + NC;
  localparam int MAX_DIM = (ROWS > COLS) ? ROWS : COLS;
  localparam int STEP_W  = $clog2(MAX_DIM);
  localparam int PH_W    = (NPH > 1) ? $clog2(NPH) : 1;
  // Vertical pair arrays keep at least one row so ROWS=1 stays legal.
  localparam int VR      = (ROWS > 1) ? ROWS - 1 : 1;

  // Packed so that cell (r,c) lands at bit (r*COLS+c)*KEY_W, matching data_in.
  typedef logic [ROWS-1:0][COLS-1:0][KEY_W-1:0] grid_t;

  state_e            state_q;
  grid_t             grid_q;
  grid_t             grid_row_d;
  grid_t             grid_col_d;
  logic [STEP_W-1:0] step_cnt_q;
  logic [PH_W-1:0]   phase_cnt_q;
  logic              busy_q;
  logic              done_q;

  logic              w_par;
  logic              w_last_step;
  logic              w_last_phase;

  logic [KEY_W-1:0]  h_lo [ROWS][COLS-1];
  logic [KEY_W-1:0]  h_hi [ROWS][COLS-1];
  logic [KEY_W-1:0]  v_lo [VR][COLS];
  logic [KEY_W-1:0]  v_hi [VR][COLS];

`ifdef MESH_SORT_EARLY_EXIT_EN
  logic [ROWS*(COLS-1)-1:0] w_h_act;
  logic [VR*COLS-1:0]       w_v_act;
  logic                     w_step_sw;
  logic                     sw_acc_q;   // any swap so far in the current phase
  logic                     row_sw_q;   // latest row phase made a swap
`endif

  assign w_par        = step_cnt_q[0];
  assign w_last_step  = (state_q == ST_ROW) ? (step_cnt_q == STEP_W'(COLS - 1))
                                            : (step_cnt_q == STEP_W'(ROWS - 1));
  assign w_last_phase = (phase_cnt_q == PH_W'(NPH - 1));

  // Horizontal compare-exchange units, one per adjacent pair in each row.
  for (genvar r = 0; r < ROWS; r++) begin : g_hrow
    for (genvar c = 0; c < COLS - 1; c++) begin : g_hpair
      localparam logic C_PAR = 1'(c % 2);
      logic w_swapped;
      mesh_cmp_swap #(.KEY_W(KEY_W)) u_cs (
        .a_i       (grid_q[r][c]),
        .b_i       (grid_q[r][c+1]),
        .desc_i    (1'(r % 2)),
        .lo_o      (h_lo[r][c]),
        .hi_o      (h_hi[r][c]),
        .swapped_o (w_swapped)
      );
`ifdef MESH_SORT_EARLY_EXIT_EN
      assign w_h_act[r*(COLS-1)+c] = w_swapped && (w_par == C_PAR);
`else
      logic w_swapped_unused;
      assign w_swapped_unused = w_swapped;
`endif
    end
  end

  // Vertical compare-exchange units, always ascending down a column.
  for (genvar r = 0; r < ROWS - 1; r++) begin : g_vrow
    for (genvar c = 0; c < COLS; c++) begin : g_vpair
      localparam logic R_PAR = 1'(r % 2);
      logic w_swapped;
      mesh_cmp_swap #(.KEY_W(KEY_W)) u_cs (
        .a_i       (grid_q[r][c]),
        .b_i       (grid_q[r+1][c]),
        .desc_i    (1'b0),
        .lo_o      (v_lo[r][c]),
        .hi_o      (v_hi[r][c]),
        .swapped_o (w_swapped)
      );
`ifdef MESH_SORT_EARLY_EXIT_EN
      assign w_v_act[r*COLS+c] = w_swapped && (w_par == R_PAR);
`else
      logic w_swapped_unused;
      assign w_swapped_unused = w_swapped;
`endif
    end
  end

`ifdef MESH_SORT_EARLY_EXIT_EN
  if (ROWS == 1) begin : g_vact_tie
    assign w_v_act = '0;
  end
  assign w_step_sw = (state_q == ST_ROW) ? (|w_h_act) : (|w_v_act);
`endif

  // Per-cell next value. A pair starting at index i is active when
  // i's parity equals the step parity; a cell belongs to at most one
  // active pair, either as its left/top member or its right/bottom one.
  for (genvar r = 0; r < ROWS; r++) begin : g_cell_r
    for (genvar c = 0; c < COLS; c++) begin : g_cell_c
      localparam logic C_PAR = 1'(c % 2);
      localparam logic R_PAR = 1'(r % 2);

      if (c == 0) begin : g_rfirst
        assign grid_row_d[r][c] = (w_par == 1'b0) ? h_lo[r][c] : grid_q[r][c];
      end else if (c == COLS - 1) begin : g_rlast
        assign grid_row_d[r][c] = (w_par != C_PAR) ? h_hi[r][c-1] : grid_q[r][c];
      end else begin : g_rmid
        assign grid_row_d[r][c] = (w_par == C_PAR) ? h_lo[r][c] : h_hi[r][c-1];
      end

      if (ROWS == 1) begin : g_ccopy
        assign grid_col_d[r][c] = grid_q[r][c];
      end else if (r == 0) begin : g_cfirst
        assign grid_col_d[r][c] = (w_par == 1'b0) ? v_lo[r][c] : grid_q[r][c];
      end else if (r == ROWS - 1) begin : g_clast
        assign grid_col_d[r][c] = (w_par != R_PAR) ? v_hi[r-1][c] : grid_q[r][c];
      end else begin : g_cmid
        assign grid_col_d[r][c] = (w_par == R_PAR) ? v_lo[r][c] : v_hi[r-1][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grid_q      <= '0;
      step_cnt_q  <= '0;
      phase_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MESH_SORT_EARLY_EXIT_EN
      sw_acc_q    <= 1'b0;
      row_sw_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            grid_q      <= data_in;
            state_q     <= ST_ROW;
            busy_q      <= 1'b1;
            step_cnt_q  <= '0;
            phase_cnt_q <= '0;
`ifdef MESH_SORT_EARLY_EXIT_EN
            sw_acc_q    <= 1'b0;
            row_sw_q    <= 1'b1;
`endif
          end
        end

        ST_ROW: begin
          grid_q <= grid_row_d;
          if (w_last_step) begin
            step_cnt_q <= '0;
`ifdef MESH_SORT_EARLY_EXIT_EN
            row_sw_q   <= sw_acc_q | w_step_sw;
            sw_acc_q   <= 1'b0;
`endif
            if (w_last_phase) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              phase_cnt_q <= phase_cnt_q + 1'b1;
              state_q     <= ST_COL;
            end
          end else begin
            step_cnt_q <= step_cnt_q + 1'b1;
`ifdef MESH_SORT_EARLY_EXIT_EN
            sw_acc_q   <= sw_acc_q | w_step_sw;
`endif
          end
        end

        ST_COL: begin
          grid_q <= grid_col_d;
          if (w_last_step) begin
            step_cnt_q  <= '0;
            phase_cnt_q <= phase_cnt_q + 1'b1;
            state_q     <= ST_ROW;
`ifdef MESH_SORT_EARLY_EXIT_EN
            sw_acc_q    <= 1'b0;
            // Sorted rows and sorted columns together form a fixed point.
            if (!row_sw_q && !(sw_acc_q | w_step_sw)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`endif
          end else begin
            step_cnt_q <= step_cnt_q + 1'b1;
`ifdef MESH_SORT_EARLY_EXIT_EN
            sw_acc_q   <= sw_acc_q | w_step_sw;
`endif
          end
        end

        ST_DONE: begin
          done_q      <= 1'b0;
          phase_cnt_q <= '0;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = grid_q;

endmodule

`default_nettype wire

// File: tb/tb_mesh_shearsort.sv
// ============================================================================
// Module      : tb_mesh_shearsort
// Description : Scoreboard bench for mesh_shearsort. A 2x2 and a 4x4 instance
//               are driven with directed and random key sets. Each accepted
//               start pushes the expected grid and latency, computed by a
//               phase-level shearsort model (whole rows/columns sorted per
//               phase), into a queue; a monitor pops and compares on done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesh_shearsort;
  import mesh_sort_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        start_a = 1'b0;
  logic [15:0] din_a   = '0;
  logic        busy_a, done_a;
  logic [15:0] dout_a;

  logic        start_b = 1'b0;
  logic [63:0] din_b   = '0;
  logic        busy_b, done_b;
  logic [63:0] dout_b;

  mesh_shearsort #(.ROWS(2), .COLS(2), .KEY_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(din_a),
    .busy(busy_a), .done(done_a), .data_out(dout_a)
  );

  mesh_shearsort #(.ROWS(4), .COLS(4), .KEY_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(din_b),
    .busy(busy_b), .done(done_b), .data_out(dout_b)
  );

  typedef struct {
    logic [63:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic void sort_n(inout int a[4], input int n, input bit desc);
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (a[j-1] < a[j]) : (a[j-1] > a[j])) begin
          int t;
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
  endfunction

  // Shearsort at phase granularity: a row phase fully sorts every row in
  // snake direction, a column phase fully sorts every column ascending.
  function automatic void model(input logic [63:0] din, input int R, input int C,
                                output logic [63:0] dout, output int lat);
    int g[4][4];
    int a[4];
    int nr, nc, steps;
    bit ch;
`ifdef MESH_SORT_EARLY_EXIT_EN
    bit row_ch;
    row_ch = 1'b1;
`endif
    nr = $clog2(R) + 1;
    nc = $clog2(R);
    steps = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        g[r][c] = int'(din[(r*C+c)*4 +: 4]);
    for (int ph = 0; ph < nr + nc; ph++) begin
      ch = 1'b0;
      if (ph % 2 == 0) begin
        for (int r = 0; r < R; r++) begin
          for (int c = 0; c < C; c++) a[c] = g[r][c];
          sort_n(a, C, (r % 2) == 1);
          for (int c = 0; c < C; c++) begin
            if (a[c] != g[r][c]) ch = 1'b1;
            g[r][c] = a[c];
          end
        end
        steps += C;
`ifdef MESH_SORT_EARLY_EXIT_EN
        row_ch = ch;
`endif
      end else begin
        for (int c = 0; c < C; c++) begin
          for (int r = 0; r < R; r++) a[r] = g[r][c];
          sort_n(a, R, 1'b0);
          for (int r = 0; r < R; r++) begin
            if (a[r] != g[r][c]) ch = 1'b1;
            g[r][c] = a[r];
          end
        end
        steps += R;
`ifdef MESH_SORT_EARLY_EXIT_EN
        if (!row_ch && !ch) break;
`endif
      end
    end
    lat  = steps + 1;
    dout = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        dout[(r*C+c)*4 +: 4] = 4'(g[r][c]);
  endfunction

  // Issue one start on instance a (sel=0) or b (sel=1).
  task automatic go(input bit sel, input logic [63:0] d, input bit push);
    exp_t e;
    logic [63:0] x;
    int l;
    @(negedge clk);
    if (sel) begin start_b = 1'b1; din_b = d; end
    else     begin start_a = 1'b1; din_a = d[15:0]; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    check(sel ? "b_busy_after_start" : "a_busy_after_start",
          64'(sel ? busy_b : busy_a), 64'd1);
    if (push) begin
      if (sel) model(d, 4, 4, x, l);
      else     model({48'd0, d[15:0]}, 2, 2, x, l);
      e.data = x; e.lat = l; e.acc = cyc;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL wait_idle: pending a=%0d b=%0d after %0d cycles, expected 0",
               q_a.size(), q_b.size(), n);
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && done_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_done: got done=1, expected no pending result");
      end else begin
        e = q_a.pop_front();
        check("a_data", 64'(dout_a), e.data);
        check("a_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        check("a_busy_at_done", 64'(busy_a), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && done_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_done: got done=1, expected no pending result");
      end else begin
        e = q_b.pop_front();
        check("b_data", dout_b, e.data);
        check("b_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        check("b_busy_at_done", 64'(busy_b), 64'd0);
      end
    end
  end

  initial begin
    logic [63:0] d;
    logic [63:0] snake;

    repeat (3) @(negedge clk);
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_dout_a", 64'(dout_a), 64'd0);
    check("rst_busy_b", 64'(busy_b), 64'd0);
    check("rst_dout_b", dout_b, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reverse keys on 2x2.
    go(1'b0, 64'h0123, 1'b1);
    wait_idle();
    check("s1_out", 64'(dout_a), 64'h2310);

    // Already snake-sorted input.
    go(1'b0, 64'h2310, 1'b1);
    wait_idle();
    check("s2_out", 64'(dout_a), 64'h2310);

    // 4x4 reverse keys -> snake order.
    for (int k = 0; k < 16; k++) d[k*4 +: 4] = 4'(15 - k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        snake[(r*4+c)*4 +: 4] = 4'(r*4 + ((r % 2) == 1 ? 3 - c : c));
    go(1'b1, d, 1'b1);
    wait_idle();
    check("s3_out", dout_b, snake);

    // All keys equal.
    go(1'b0, 64'h5555, 1'b1);
    wait_idle();
    check("s4_out", 64'(dout_a), 64'h5555);

    // Extra start while busy must be ignored.
    go(1'b0, 64'h0123, 1'b1);
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    din_a   = 16'hF0F0;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle();
    check("s5_out", 64'(dout_a), 64'h2310);

    // Reset mid-sort aborts without a done pulse.
    go(1'b0, 64'h0123, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("s6_busy", 64'(busy_a), 64'd0);
    check("s6_done", 64'(done_a), 64'd0);
    check("s6_dout", 64'(dout_a), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    go(1'b0, 64'h0123, 1'b1);
    wait_idle();

    // Random key sets, both meshes running concurrently.
    for (int i = 0; i < 24; i++) begin
      go(1'b0, 64'(16'($urandom)), 1'b1);
      go(1'b1, {32'($urandom), 32'($urandom)}, 1'b1);
      if (i % 3 == 0) begin
        @(negedge clk);
        start_a = 1'b1;
        start_b = 1'b1;
        din_a   = 16'($urandom);
        din_b   = {32'($urandom), 32'($urandom)};
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
      end
      wait_idle();
    end

    // Small-range random keys exercise duplicates.
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 16; k++) d[k*4 +: 4] = 4'($urandom_range(0, 2));
      go(1'b1, d, 1'b1);
      go(1'b0, d, 1'b1);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
